// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the master-port state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA
  } state_e;

endpackage

// File: rtl/ahb_master_if_if.sv
// Bus-side signal bundle between a master port and the arbiter/slave fabric.
interface ahb_master_if_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              hreq;
  logic [1:0]        sel;
  logic              hgrant;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output hreq, sel, haddr, htrans, hwrite, hsize, hwdata,
    input  hgrant, hrdata, hready, hresp
  );

  modport slave (
    input  hreq, sel, haddr, htrans, hwrite, hsize, hwdata,
    output hgrant, hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_wait_timer.sv
// Clearable per-state wait counter; flags the WAIT_MAX-th cycle spent in a state.
module ahb_wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam bit            ENABLED = (WAIT_MAX != 0);
  localparam logic [CW-1:0] LAST    = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed cycles, so the cycle seen with cnt_q==LAST is the WAIT_MAX-th one.
  assign expired = ENABLED && en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ENABLED && en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master port: request, one NONSEQ word transfer, response with timeout.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  ahb_master_if_if.master   bus
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hreq_q, hreq_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic tmr_clr, tmr_expired, completing;

  ahb_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .hclk    (hclk),
    .hresetn (hresetn),
    .clr     (tmr_clr),
    .en      (state_q != ST_IDLE),
    .expired (tmr_expired)
  );

  assign tmr_clr    = (state_d != state_q) || (state_q == ST_IDLE);
  assign completing = (state_q == ST_DATA) && bus.hready;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    hreq_d        = hreq_q;
    sel_d         = sel_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          hreq_d  = 1'b1;
          sel_d   = cmd_sel;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.hgrant) begin
          haddr_d  = addr_q;
          hwrite_d = write_q;
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!bus.hgrant) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_REQ;
        end else if (bus.hready) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = write_q ? wdata_q : '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.hready) begin
          hreq_d        = 1'b0;
          sel_d         = '0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.hresp;
          rsp_timeout_d = 1'b0;
          if (!write_q) rsp_rdata_d = bus.hrdata;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout overrides any other move except a completing data phase.
    if (tmr_expired && !completing) begin
      hreq_d        = 1'b0;
      sel_d         = '0;
      htrans_d      = HTRANS_IDLE;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_err_d     = 1'b0;
      state_d       = ST_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      hreq_q        <= 1'b0;
      sel_q         <= '0;
      haddr_q       <= '0;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      hreq_q        <= hreq_d;
      sel_q         <= sel_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  assign bus.hreq   = hreq_q;
  assign bus.sel    = sel_q;
  assign bus.haddr  = haddr_q;
  assign bus.htrans = htrans_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hsize  = HSIZE_WORD;
  assign bus.hwdata = hwdata_q;

endmodule
